// File: rtl/compute_pkg.sv
// Shared types and constants for the matrix-multiply run controller.
package compute_pkg;

  localparam int ADDR_W = 5;

  localparam logic [1:0] ENG_PE   = 2'd0;
  localparam logic [1:0] ENG_SA3  = 2'd1;
  localparam logic [1:0] ENG_SA2  = 2'd2;
  localparam logic [1:0] ENG_NONE = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SETTLE,
    LAUNCH,
    WAIT,
    WRITE,
    FINISH
  } state_t;

  // Lowest enabled engine index that is >= from; ENG_NONE when nothing is left.
  function automatic logic [1:0] first_enabled(input logic [2:0] mask, input logic [2:0] from);
    logic [1:0] sel;
    sel = ENG_NONE;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) sel = 2'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/compute_sequencer_if.sv
// Control/handshake bundle between the run sequencer, its engines and the memory.
interface compute_sequencer_if;
  import compute_pkg::*;

  logic                  start_i;
  logic [2:0]            eng_en_i;
  logic                  run_valid_o;
  logic [2:0]            eng_start_o;
  logic [2:0]            eng_done_i;
  logic [3*ADDR_W-1:0]   eng_addr_i;
  logic [ADDR_W-1:0]     addr_core_o;
  logic                  pe_valid_o;
  logic                  sa3_valid_o;
  logic                  sa2_valid_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [1:0]            err_eng_o;

  modport master (
    output start_i, eng_en_i, eng_done_i, eng_addr_i,
    input  run_valid_o, eng_start_o, addr_core_o, pe_valid_o, sa3_valid_o,
           sa2_valid_o, busy_o, done_o, err_o, err_eng_o
  );

  modport slave (
    input  start_i, eng_en_i, eng_done_i, eng_addr_i,
    output run_valid_o, eng_start_o, addr_core_o, pe_valid_o, sa3_valid_o,
           sa2_valid_o, busy_o, done_o, err_o, err_eng_o
  );

endinterface

// File: rtl/eng_watchdog.sv
// Per-engine watchdog: counts cycles since the start pulse and flags a hung engine.
module eng_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // The count equals the number of cycles elapsed since the start pulse, so
  // expiring one short of the limit lands the abort exactly on the limit.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/compute_sequencer.sv
// Run controller: captures operands, then runs enabled engines in order PE, SA_3x3, SA_2x2.
module compute_sequencer
  import compute_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input logic               clk,
  input logic               reset,
  compute_sequencer_if.slave bus
);

  state_t            state, state_nx;
  logic [2:0]        mask, mask_nx;
  logic [1:0]        eng, eng_nx;
  logic              err, err_nx;
  logic [1:0]        err_eng, err_eng_nx;
  logic              empty_done, empty_done_nx;
  logic              wd_run, wd_clear, wd_expire;
  logic [ADDR_W-1:0] addr_sel;
  logic              done_sel;
  logic              addr_phase;

  assign wd_run   = (state == LAUNCH) || (state == WAIT);
  assign wd_clear = !wd_run;

  eng_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (wd_clear),
    .enable(wd_run),
    .expire(wd_expire)
  );

  always_comb begin
    addr_sel = '0;
    done_sel = 1'b0;
    case (eng)
      ENG_PE: begin
        addr_sel = bus.eng_addr_i[ADDR_W-1:0];
        done_sel = bus.eng_done_i[0];
      end
      ENG_SA3: begin
        addr_sel = bus.eng_addr_i[2*ADDR_W-1:ADDR_W];
        done_sel = bus.eng_done_i[1];
      end
      ENG_SA2: begin
        addr_sel = bus.eng_addr_i[3*ADDR_W-1:2*ADDR_W];
        done_sel = bus.eng_done_i[2];
      end
      default: begin
        addr_sel = '0;
        done_sel = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mask       <= '0;
      eng        <= ENG_NONE;
      err        <= 1'b0;
      err_eng    <= ENG_NONE;
      empty_done <= 1'b0;
    end else begin
      state      <= state_nx;
      mask       <= mask_nx;
      eng        <= eng_nx;
      err        <= err_nx;
      err_eng    <= err_eng_nx;
      empty_done <= empty_done_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    mask_nx       = mask;
    eng_nx        = eng;
    err_nx        = err;
    err_eng_nx    = err_eng;
    empty_done_nx = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.eng_en_i != 3'b000) begin
            mask_nx    = bus.eng_en_i;
            err_nx     = 1'b0;
            err_eng_nx = ENG_NONE;
            state_nx   = CAPTURE;
          end else begin
            empty_done_nx = 1'b1;
          end
        end
      end
      CAPTURE: state_nx = SETTLE;
      SETTLE: begin
        eng_nx   = first_enabled(mask, 3'd0);
        state_nx = (eng_nx == ENG_NONE) ? FINISH : LAUNCH;
      end
      LAUNCH: state_nx = WAIT;
      WAIT: begin
        // A done in the same cycle as expiry still counts as a normal finish.
        if (done_sel) begin
          state_nx = WRITE;
        end else if (wd_expire) begin
          err_nx     = 1'b1;
          err_eng_nx = eng;
          state_nx   = FINISH;
        end
      end
      WRITE: begin
        eng_nx   = first_enabled(mask, {1'b0, eng} + 3'd1);
        state_nx = (eng_nx == ENG_NONE) ? FINISH : LAUNCH;
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign addr_phase = (state == LAUNCH) || (state == WAIT) || (state == WRITE);

  assign bus.run_valid_o = (state == CAPTURE);
  assign bus.eng_start_o = (state == LAUNCH) ? (3'b001 << eng) : 3'b000;
  assign bus.addr_core_o = addr_phase ? addr_sel : '0;
  assign bus.pe_valid_o  = (state == WRITE) && (eng == ENG_PE);
  assign bus.sa3_valid_o = (state == WRITE) && (eng == ENG_SA3);
  assign bus.sa2_valid_o = (state == WRITE) && (eng == ENG_SA2);
  assign bus.busy_o      = (state != IDLE);
  assign bus.done_o      = (state == FINISH) || empty_done;
  assign bus.err_o       = err;
  assign bus.err_eng_o   = err_eng;

endmodule

// File: doc/compute_sequencer.md
Name: compute_sequencer

Overview:
Top-level run controller for the matrix-multiply subsystem. On a start pulse it captures the operand set into the operand/result memory. It then runs the enabled engines one at a time, in the fixed order PE, SA_3x3, SA_2x2. While an engine runs, the sequencer gives it the single core read port of the memory. When the engine finishes, the sequencer pulses that engine's result-write strobe. A per-engine watchdog aborts a hung engine and reports an error.

Parameters:
TIMEOUT_CYCLES, 255, max cycles from an engine start pulse to its done; counted in a CNT_W-bit counter
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start_i  input  1  run request; sampled only in IDLE
eng_en_i  input  3  engine enable mask, sampled with start_i; bit0 PE, bit1 SA_3x3, bit2 SA_2x2
run_valid_o  output  1  one-cycle capture strobe to memory (memory run_valid_i)
eng_start_o  output  3  one-cycle start pulse per engine, same bit order as eng_en_i
eng_done_i  input  3  one-cycle done pulse per engine; result on c11..c22 is valid in the same cycle
eng_addr_i  input  15  three 5-bit read addresses: [4:0] PE, [9:5] SA_3x3, [14:10] SA_2x2
addr_core_o  output  5  memory core read address
pe_valid_o  output  1  result-write strobe to memory (PE_valid_i)
sa3_valid_o  output  1  result-write strobe to memory (SA_3x3_valid_i)
sa2_valid_o  output  1  result-write strobe to memory (SA_2x2_valid_i)
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle pulse when a run completes, normally or by abort
err_o  output  1  sticky timeout flag; cleared by the next accepted start
err_eng_o  output  2  index of the timed-out engine (0 PE, 1 SA_3x3, 2 SA_2x2); 3 means none

Behaviour:
- Reset values: all outputs 0, except err_eng_o = 3. State is IDLE, enable mask is 0, watchdog count is 0.
- Reset asserted mid-run returns immediately to IDLE with the reset output values. No valid strobe is emitted.
- States: IDLE, CAPTURE, SETTLE, LAUNCH, WAIT, WRITE, FINISH.
- IDLE:
  - If start_i=1 and eng_en_i != 0: latch the mask, clear err_o, set err_eng_o=3, go to CAPTURE.
  - If start_i=1 and eng_en_i == 0: pulse done_o in the next cycle and stay in IDLE. No capture happens.
- CAPTURE: run_valid_o=1 for exactly this cycle, then go to SETTLE. Operands are in memory at the end of this cycle.
- SETTLE: one cycle, so reads see the new operands. Select the lowest enabled engine index, then go to LAUNCH.
- LAUNCH: eng_start_o[k]=1 for one cycle, watchdog count = 0, go to WAIT.
- WAIT:
  - addr_core_o = the 5-bit slice of eng_addr_i for engine k, combinationally, during LAUNCH, WAIT and WRITE. addr_core_o = 0 in every other state.
  - Watchdog increments each cycle.
  - If eng_done_i[k]=1, go to WRITE.
  - Else if count reaches TIMEOUT_CYCLES: set err_o=1, err_eng_o=k, go to FINISH. Remaining engines are skipped and no result strobe is emitted.
  - eng_done_i bits of non-active engines are ignored.
- Result strobe: the registered strobe for engine k (pe/sa3/sa2_valid_o) is high for exactly one cycle, in the cycle after done is sampled (the WRITE state). The engine must hold c11..c22 stable until its next start.
- WRITE: go to LAUNCH for the next higher enabled engine in the latched mask. If none is left, go to FINISH.
- FINISH: done_o=1 for one cycle, go to IDLE.
- At most one bit of eng_start_o and at most one valid strobe are high in any cycle. The three valid strobes are mutually exclusive.
- start_i outside IDLE is ignored and not queued.
- Minimum run with one engine whose done arrives in the cycle after start is 6 cycles from start sample to done_o: CAPTURE, SETTLE, LAUNCH, WAIT, WRITE, FINISH.

Decomposition:
- Package compute_pkg holds:
  - the state enum;
  - engine index constants ENG_PE=0, ENG_SA3=1, ENG_SA2=2, ENG_NONE=3;
  - the address width constant ADDR_W=5.
- Sub-module eng_watchdog holds the clear/enable/expire counter (CNT_W, TIMEOUT_CYCLES).
- The FSM and the address mux stay in compute_sequencer.

Test Plan:
- Full run: reset, then start_i=1 with eng_en_i=3'b111. Engines return done 4, 10 and 7 cycles after their start pulses.
  - Required: run_valid_o high 1 cycle.
  - Required: start pulses in order PE, SA3, SA2.
  - Required: pe/sa3/sa2 strobes each high 1 cycle, each one cycle after the matching done.
  - Required: done_o pulses once; err_o=0.
- Address mux: during the SA_3x3 phase drive eng_addr_i slices PE=5, SA3=17, SA2=9. Required: addr_core_o=17. In IDLE, addr_core_o=0.
- Sparse mask: eng_en_i=3'b100. Required: only eng_start_o[2] pulses and only sa2_valid_o pulses. Done with an immediate done response is exactly 6 cycles after start.
- Timeout: eng_en_i=3'b011, SA3 never returns done, TIMEOUT_CYCLES=255.
  - Required: err_o=1 and err_eng_o=1 exactly 255 cycles after the SA3 start; no sa3_valid_o; done_o pulses.
  - Then a new start clears err_o and sets err_eng_o=3.
- Reset mid-run: assert reset during the PE WAIT state. Required: all outputs go to 0 and err_eng_o=3 immediately. A later PE done pulse produces no strobe.
- Edge inputs:
  - start_i=1 with eng_en_i=0: done_o pulses, no run_valid_o.
  - start_i held high throughout a run: no re-trigger until IDLE.
  - Spurious eng_done_i[2] pulse during the PE phase: ignored.
